aes_iter_encrypt: RTL and testbench
===================================

AES_ITER_ENCRYPT -- requirements
Module: aes_iter_encrypt

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128, key length; legal values 128 and 256, any other value is an elaboration error.
REQ-002 SHALL have parameter NR, derived and not overridable: 10 when KEY_BITS=128, 14 when KEY_BITS=256.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, plaintext and key present.
REQ-006 SHALL have port in_ready, output, 1, core can accept a block.
REQ-007 SHALL have port hex_input, input, 128, plaintext in FIPS-197 byte order, MSB = byte 0.
REQ-008 SHALL have port key, input, KEY_BITS, cipher key, MSB = byte 0.
REQ-009 SHALL have port out_valid, output, 1, encrypt_data holds a finished ciphertext.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the ciphertext.
REQ-011 SHALL have port encrypt_data, output, 128, ciphertext.
REQ-012 SHALL have port busy, output, 1, high in states ROUND and DONE.

Function
REQ-013 SHALL implement the FSM states IDLE, ROUND and DONE.
REQ-014 SHALL transfer input only when in_valid and in_ready are both high; in_ready SHALL be high only in IDLE.
REQ-015 On input transfer, SHALL register state = hex_input XOR key[KEY_BITS-1 -: 128] (round 0), latch the full key into the key window, set round counter rnd=1 and go to ROUND.
REQ-016 In ROUND, SHALL perform exactly one AES round per cycle: SubBytes, ShiftRows, MixColumns, AddRoundKey; MixColumns is skipped when rnd==NR.
REQ-017 SHALL generate round keys on the fly, one per cycle, from a KEY_BITS-wide key window; no round-key storage array.
REQ-018 For KEY_BITS=256, the key window SHALL advance every second round, alternating halves, with RotWord+Rcon on the even expansion step and SubWord only on the odd one, per FIPS-197.
REQ-019 Rcon SHALL come from a 10-entry constant table indexed by the expansion step; it SHALL NOT be indexed by rnd directly.
REQ-020 When rnd==NR completes, SHALL load encrypt_data, assert out_valid and go to DONE; latency from input transfer to out_valid is NR+1 cycles (11 for 128, 15 for 256).
REQ-021 In DONE, out_valid and encrypt_data SHALL hold stable until out_ready is high.
REQ-022 When out_ready is high in DONE, SHALL deassert out_valid next cycle and return to IDLE.
REQ-023 The core SHALL NOT accept new input in the same cycle as output transfer; sustained throughput is one block per NR+2 cycles.
REQ-024 Changes on hex_input or key after input transfer SHALL NOT affect the result in flight.
REQ-025 out_ready high while out_valid is low SHALL have no effect.

Reset
REQ-026 On rst_n low, the FSM SHALL go to IDLE immediately; out_valid=0, busy=0, in_ready=0 while in reset, encrypt_data=0, rnd=0.
REQ-027 in_ready SHALL go high on the first clk edge after rst_n deasserts.
REQ-028 A reset in ROUND or DONE SHALL discard the block in flight, and no out_valid pulse SHALL follow.

Configuration
REQ-029 The block SHALL support macro AES_BLOCK_COUNT_EN.
REQ-030 When AES_BLOCK_COUNT_EN is defined, SHALL provide output blk_count[31:0]: reset 0, increments on each output transfer, wraps from 0xFFFFFFFF to 0.
REQ-031 When AES_BLOCK_COUNT_EN is undefined, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package aes_pkg SHALL hold: S-box function, xtime function, Rcon table, FSM state enum, and NR derivation function.
REQ-033 SHALL contain one sub-module, aes_round_step: combinational round with a last-round input that bypasses MixColumns, taking state and round key and producing the next state.
REQ-034 Key expansion, the FSM and the handshake SHALL reside in aes_iter_encrypt.

Verification
REQ-035 The bench SHALL cover: KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> encrypt_data 3925841d02dc09fbdc118597196a0b32, out_valid 11 cycles after transfer.
REQ-036 The bench SHALL cover: KEY_BITS=128, key 000102...0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-037 The bench SHALL cover: KEY_BITS=256, key 000102...1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, out_valid 15 cycles after transfer.
REQ-038 The bench SHALL cover: out_ready held low 20 cycles -> out_valid and data stable, in_ready low throughout; out_ready high -> IDLE next cycle.
REQ-039 The bench SHALL cover: rst_n pulsed low at rnd=5 -> outputs zero at once, no out_valid; next block encrypts correctly.
REQ-040 The bench SHALL cover, with AES_BLOCK_COUNT_EN: 3 back-to-back blocks -> blk_count=3; a preload near 0xFFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_pkg : shared AES arithmetic (GF(2^8), S-box, key words), Rcon table, FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic int nr_for(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] expand_quad(input logic [127:0] base, input logic [31:0] t);
    logic [31:0] n0, n1, n2, n3;
    n0 = base[127:96] ^ t;
    n1 = base[95:64]  ^ n0;
    n2 = base[63:32]  ^ n1;
    n3 = base[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_round_step : one combinational AES round; last skips MixColumns
// Rev 1.0
// ----------------------------------------------------------------------------
module aes_round_step
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] w_sr;
  logic [127:0] w_mc;

  // Byte i of the block sits at row i%4, column i/4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a [4];
    logic [7:0] w_x [4];
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 4 * c + r;
      localparam int SRC = 4 * ((c + r) % 4) + r;
      assign w_a[r] = sbox(state_in[127 - 8 * SRC -: 8]);
      assign w_x[r] = xtime(w_a[r]);
      assign w_sr[127 - 8 * DST -: 8] = w_a[r];
    end
    assign w_mc[127 - 32 * c -: 32] = {
      w_x[0] ^ w_x[1] ^ w_a[1] ^ w_a[2] ^ w_a[3],
      w_a[0] ^ w_x[1] ^ w_x[2] ^ w_a[2] ^ w_a[3],
      w_a[0] ^ w_a[1] ^ w_x[2] ^ w_x[3] ^ w_a[3],
      w_x[0] ^ w_a[0] ^ w_a[1] ^ w_a[2] ^ w_x[3]
    };
  end

  assign state_out = (last ? w_sr : w_mc) ^ round_key;

endmodule
`default_nettype wire

// File: rtl/aes_iter_encrypt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_iter_encrypt : iterative AES-128/256 encryptor, one round per clock.
// Optional macro AES_BLOCK_COUNT_EN adds the blk_count output. Rev 1.0
// ----------------------------------------------------------------------------
module aes_iter_encrypt
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        hex_input,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        encrypt_data,
  output logic                busy
`ifdef AES_BLOCK_COUNT_EN
  ,
  output logic [31:0]         blk_count
`endif
);

  localparam int NR = nr_for(KEY_BITS);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_alive;
  logic [3:0]          r_rnd;
  logic [3:0]          r_rcon_idx;
  logic [127:0]        r_blk;
  logic [KEY_BITS-1:0] r_win;
  logic [KEY_BITS-1:0] w_win_next;
  logic [127:0]        w_rkey;
  logic [127:0]        w_round_out;
  logic                w_rcon_adv;
  logic                w_last;
  logic                w_xfer_in;

  assign w_last    = (r_rnd == 4'(NR));
  assign in_ready  = r_alive && (r_state == IDLE);
  assign w_xfer_in = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == ROUND) || (r_state == DONE);

  if (KEY_BITS == 128) begin : g_k128
    logic [31:0] w_t;
    assign w_t        = sub_word(rot_word(r_win[31:0])) ^ {RCON[r_rcon_idx], 24'h0};
    assign w_rkey     = expand_quad(r_win, w_t);
    assign w_win_next = w_rkey;
    assign w_rcon_adv = 1'b1;
  end else if (KEY_BITS == 256) begin : g_k256
    // Round 1 uses the second key half as-is; afterwards even rounds rewrite the
    // upper half (RotWord+Rcon) and odd rounds rewrite the lower half (SubWord).
    logic         w_first;
    logic         w_even;
    logic [31:0]  w_t;
    logic [127:0] w_fresh;
    assign w_first    = (r_rnd == 4'd1);
    assign w_even     = ~r_rnd[0];
    assign w_t        = w_even ? (sub_word(rot_word(r_win[31:0])) ^ {RCON[r_rcon_idx], 24'h0})
                               : sub_word(r_win[159:128]);
    assign w_fresh    = expand_quad(w_even ? r_win[255:128] : r_win[127:0], w_t);
    assign w_rkey     = w_first ? r_win[127:0] : w_fresh;
    assign w_win_next = w_first ? r_win
                      : (w_even ? {w_fresh, r_win[127:0]} : {r_win[255:128], w_fresh});
    assign w_rcon_adv = w_even;
  end else begin : g_bad_key_bits
    $error("aes_iter_encrypt: KEY_BITS must be 128 or 256");
    assign w_rkey     = '0;
    assign w_win_next = '0;
    assign w_rcon_adv = 1'b0;
  end

  aes_round_step u_round (
    .state_in  (r_blk),
    .round_key (w_rkey),
    .last      (w_last),
    .state_out (w_round_out)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer_in) w_state_next = ROUND;
      ROUND:   if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_alive      <= 1'b0;
      r_rnd        <= 4'd0;
      r_rcon_idx   <= 4'd0;
      r_blk        <= '0;
      r_win        <= '0;
      encrypt_data <= '0;
    end else begin
      r_state <= w_state_next;
      r_alive <= 1'b1;
      if (w_xfer_in) begin
        r_blk      <= hex_input ^ key[KEY_BITS-1 -: 128];
        r_win      <= key;
        r_rnd      <= 4'd1;
        r_rcon_idx <= 4'd0;
      end else if (r_state == ROUND) begin
        r_blk <= w_round_out;
        r_win <= w_win_next;
        if (w_last) begin
          encrypt_data <= w_round_out;
          r_rnd        <= 4'd0;
        end else begin
          r_rnd <= r_rnd + 4'd1;
          if (w_rcon_adv) r_rcon_idx <= r_rcon_idx + 4'd1;
        end
      end
    end
  end

`ifdef AES_BLOCK_COUNT_EN
  logic [31:0] r_blk_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_blk_count <= 32'd0;
    else if (out_valid && out_ready)  r_blk_count <= r_blk_count + 32'd1;
  end
  assign blk_count = r_blk_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_encrypt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aes_iter_encrypt : scoreboard bench for AES-128 and AES-256 instances
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_aes_iter_encrypt;

  localparam logic [127:0] C_PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_K2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] C_K3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C_CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] pt;
  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [127:0] key_a, ct_a;
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [255:0] key_b;
  logic [127:0] ct_b;
`ifdef AES_BLOCK_COUNT_EN
  logic [31:0]  cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  aes_iter_encrypt #(.KEY_BITS(128)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .hex_input(pt), .key(key_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .encrypt_data(ct_a), .busy(busy_a)
`ifdef AES_BLOCK_COUNT_EN
    , .blk_count(cnt_a)
`endif
  );

  aes_iter_encrypt #(.KEY_BITS(256)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .hex_input(pt), .key(key_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .encrypt_data(ct_b), .busy(busy_b)
`ifdef AES_BLOCK_COUNT_EN
    , .blk_count(cnt_b)
`endif
  );

  typedef struct {
    logic [127:0] data;
    int           xfer;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitors: compare on every new out_valid against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && !prev_a) begin
      if (q_a.size() == 0) check("a_unexpected_out_valid", 256'(1), 256'(0));
      else begin
        e_a = q_a.pop_front();
        check("a_data", 256'(ct_a), 256'(e_a.data));
        check("a_latency", 256'(cyc + 1 - e_a.xfer), 256'(11));
      end
    end
    prev_a = out_valid_a;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_b && !prev_b) begin
      if (q_b.size() == 0) check("b_unexpected_out_valid", 256'(1), 256'(0));
      else begin
        e_b = q_b.pop_front();
        check("b_data", 256'(ct_b), 256'(e_b.data));
        check("b_latency", 256'(cyc + 1 - e_b.xfer), 256'(15));
      end
    end
    prev_b = out_valid_b;
  end

  task automatic send_a(input logic [127:0] p, input logic [127:0] k, input logic [127:0] e,
                        output int xfer);
    int w;
    w = 0;
    @(negedge clk);
    pt = p; key_a = k; in_valid_a = 1'b1;
    while (!in_ready_a && w < 40) begin @(negedge clk); w++; end
    xfer = cyc + 1;
    if (in_ready_a) q_a.push_back('{data: e, xfer: xfer});
    else check("a_accept_timeout", 256'(in_ready_a), 256'(1));
    @(negedge clk);
    in_valid_a = 1'b0;
    pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic send_b(input logic [127:0] p, input logic [255:0] k, input logic [127:0] e);
    int w;
    w = 0;
    @(negedge clk);
    pt = p; key_b = k; in_valid_b = 1'b1;
    while (!in_ready_b && w < 40) begin @(negedge clk); w++; end
    if (in_ready_b) q_b.push_back('{data: e, xfer: cyc + 1});
    else check("b_accept_timeout", 256'(in_ready_b), 256'(1));
    @(negedge clk);
    in_valid_b = 1'b0;
    pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_b = {8{$urandom()}};
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || out_valid_a || out_valid_b) && w < 60) begin
      @(negedge clk);
      w++;
    end
    check(name, 256'(q_a.size() + q_b.size()), 256'(0));
  endtask

  initial begin
    int x0, x1, x2, w;
    rst_n = 1'b0; pt = '0; key_a = '0; key_b = '0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready_a = 1'b1; out_ready_b = 1'b1;
    #1;
    check("reset_outputs_a", 256'({in_ready_a, out_valid_a, busy_a, ct_a}), 256'(0));
    check("reset_outputs_b", 256'({in_ready_b, out_valid_b, busy_b, ct_b}), 256'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready_before_edge", 256'(in_ready_a), 256'(0));
    @(negedge clk);
    check("in_ready_first_edge", 256'({in_ready_a, in_ready_b}), 256'(2'b11));

    send_a(C_PT1, C_K1, C_CT1, x0);
    drain("drain_fips128");
    send_a(C_PT2, C_K2, C_CT2, x0);
    drain("drain_nist128");
    send_b(C_PT2, C_K3, C_CT3);
    drain("drain_nist256");

    // Output stall: hold out_ready low for 20 cycles.
    out_ready_a = 1'b0;
    send_a(C_PT1, C_K1, C_CT1, x0);
    w = 0;
    while (!out_valid_a && w < 40) begin @(negedge clk); w++; end
    for (int i = 0; i < 20; i++) begin
      check("stall_hold", 256'({out_valid_a, in_ready_a, busy_a, ct_a}),
            256'({1'b1, 1'b0, 1'b1, C_CT1}));
      @(negedge clk);
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    check("stall_release_idle", 256'({out_valid_a, in_ready_a, busy_a}), 256'(3'b010));

    // Reset in the middle of round 5 discards the block.
    send_a(C_PT2, C_K2, C_CT2, x0);
    repeat (4) @(negedge clk);
    check("busy_before_reset", 256'(busy_a), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 256'({out_valid_a, busy_a, in_ready_a, ct_a}), 256'(0));
    q_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_out_after_reset", 256'({out_valid_a, busy_a}), 256'(0));

    // Three back-to-back blocks after reset; period must be NR+2.
    send_a(C_PT1, C_K1, C_CT1, x0);
    send_a(C_PT2, C_K2, C_CT2, x1);
    send_a(C_PT1, C_K1, C_CT1, x2);
    check("throughput_1", 256'(x1 - x0), 256'(12));
    check("throughput_2", 256'(x2 - x1), 256'(12));
    drain("drain_b2b");
`ifdef AES_BLOCK_COUNT_EN
    check("blk_count_3", 256'(cnt_a), 256'(3));
    @(negedge clk);
    dut_a.r_blk_count <= 32'hFFFF_FFFE;
    send_a(C_PT2, C_K2, C_CT2, x0);
    drain("drain_wrap1");
    check("blk_count_max", 256'(cnt_a), 256'(32'hFFFF_FFFF));
    send_a(C_PT2, C_K2, C_CT2, x0);
    drain("drain_wrap2");
    check("blk_count_wrap", 256'(cnt_a), 256'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
